// File: rtl/regwb_arbiter_pkg.sv
// Shared constants for the register write-back arbiter: default widths,
// requester indices and the round-robin index helper.
package regwb_arbiter_pkg;
  localparam int ADDRSIZE_DEF = 5;
  localparam int NREQ_DEF     = 3;
  localparam int DATA_W       = 32;

  localparam int REQ_ALU = 0;
  localparam int REQ_LSU = 1;
  localparam int REQ_MUL = 2;

  // (base + k) mod n, for base < n and k <= n
  function automatic int rr_add(input int base, input int k, input int n);
    int s;
    s = base + k;
    if (s >= n) s = s - n;
    return s;
  endfunction
endpackage

// File: rtl/regwb_arbiter_rr_pick2.sv
// Round-robin scan from p: first valid requester takes port 0, the next one
// with a different destination address takes port 1.
module rr_pick2 import regwb_arbiter_pkg::*; #(
  parameter int ADDRSIZE = ADDRSIZE_DEF,
  parameter int NREQ     = NREQ_DEF,
  parameter int IW       = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0]               valid_i,
  input  logic [NREQ-1:0][ADDRSIZE-1:0] addr_i,
  input  logic [IW-1:0]                 p_i,
  output logic [IW-1:0]                 g0_idx_o,
  output logic [IW-1:0]                 g1_idx_o,
  output logic                          g0_vld_o,
  output logic                          g1_vld_o
);
  always_comb begin
    logic [IW-1:0] idx;
    logic [IW-1:0] i0, i1;
    logic          v0, v1;
    idx = '0;
    i0  = '0;
    i1  = '0;
    v0  = 1'b0;
    v1  = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      idx = IW'(rr_add(int'(p_i), k, NREQ));
      if (valid_i[idx]) begin
        if (!v0) begin
          v0 = 1'b1;
          i0 = idx;
        end else if (!v1 && (addr_i[idx] != addr_i[i0])) begin
          // same-address requesters wait so the two ports never collide
          v1 = 1'b1;
          i1 = idx;
        end
      end
    end
    g0_idx_o = i0;
    g1_idx_o = i1;
    g0_vld_o = v0;
    g1_vld_o = v1;
  end
endmodule

// File: rtl/regwb_arbiter.sv
// Two-port register-file write-back arbiter: combinational grant to up to two
// requesters, registered write ports, round-robin pointer and busy flag.
module regwb_arbiter import regwb_arbiter_pkg::*; #(
  parameter int ADDRSIZE = ADDRSIZE_DEF,
  parameter int NREQ     = NREQ_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NREQ-1:0]          req_valid,
  input  logic [NREQ*ADDRSIZE-1:0] req_addr,
  input  logic [NREQ*DATA_W-1:0]   req_data,
  output logic [NREQ-1:0]          req_ready,
  input  logic                     hold,
  output logic [1:0]               write,
  output logic [ADDRSIZE-1:0]      wa0,
  output logic [ADDRSIZE-1:0]      wa1,
  output logic [DATA_W-1:0]        wd0,
  output logic [DATA_W-1:0]        wd1,
  output logic                     busy
);
  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [NREQ-1:0][ADDRSIZE-1:0] addr_a;
  logic [NREQ-1:0][DATA_W-1:0]   data_a;
  assign addr_a = req_addr;
  assign data_a = req_data;

  logic [IW-1:0]       p_q, p_d;
  logic [IW-1:0]       g0_idx, g1_idx;
  logic                g0_vld, g1_vld, g0_ok, g1_ok;
  logic [1:0]          write_q, write_d;
  logic [ADDRSIZE-1:0] wa0_q, wa0_d, wa1_q, wa1_d;
  logic [DATA_W-1:0]   wd0_q, wd0_d, wd1_q, wd1_d;
  logic                busy_q, busy_d;

  rr_pick2 #(.ADDRSIZE(ADDRSIZE), .NREQ(NREQ), .IW(IW)) u_pick (
    .valid_i  (req_valid),
    .addr_i   (addr_a),
    .p_i      (p_q),
    .g0_idx_o (g0_idx),
    .g1_idx_o (g1_idx),
    .g0_vld_o (g0_vld),
    .g1_vld_o (g1_vld)
  );

  // rst gates the grant so nothing is accepted while the block is in reset
  assign g0_ok = g0_vld & ~hold & rst;
  assign g1_ok = g1_vld & ~hold & rst;

  always_comb begin
    req_ready = '0;
    if (g0_ok) req_ready[g0_idx] = 1'b1;
    if (g1_ok) req_ready[g1_idx] = 1'b1;
  end

  always_comb begin
    p_d     = p_q;
    write_d = {g1_ok, g0_ok};
    wa0_d   = wa0_q;
    wd0_d   = wd0_q;
    wa1_d   = wa1_q;
    wd1_d   = wd1_q;
    busy_d  = |(req_valid & ~req_ready);
    if (g0_ok) begin
      wa0_d = addr_a[g0_idx];
      wd0_d = data_a[g0_idx];
      p_d   = IW'(rr_add(int'(g0_idx), 1, NREQ));
    end
    if (g1_ok) begin
      wa1_d = addr_a[g1_idx];
      wd1_d = data_a[g1_idx];
      p_d   = IW'(rr_add(int'(g1_idx), 1, NREQ));
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      p_q     <= '0;
      write_q <= '0;
      wa0_q   <= '0;
      wd0_q   <= '0;
      wa1_q   <= '0;
      wd1_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      p_q     <= p_d;
      write_q <= write_d;
      wa0_q   <= wa0_d;
      wd0_q   <= wd0_d;
      wa1_q   <= wa1_d;
      wd1_q   <= wd1_d;
      busy_q  <= busy_d;
    end
  end

  assign write = write_q;
  assign wa0   = wa0_q;
  assign wa1   = wa1_q;
  assign wd0   = wd0_q;
  assign wd1   = wd1_q;
  assign busy  = busy_q;
endmodule

// File: tb/tb_regwb_arbiter.sv
// Bench for regwb_arbiter: directed vector table, reset/fairness sequences and
// randomized traffic against a queue-based scan model.
module tb_regwb_arbiter;
  localparam int AW = 5;
  localparam int N  = 3;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            hold = 1'b0;
  logic [N-1:0]    req_valid = '0;
  logic [N*AW-1:0] req_addr = '0;
  logic [N*32-1:0] req_data = '0;
  logic [N-1:0]    req_ready;
  logic [1:0]      write;
  logic [AW-1:0]   wa0, wa1;
  logic [31:0]     wd0, wd1;
  logic            busy;

  int total = 0;
  int bad   = 0;

  regwb_arbiter #(.ADDRSIZE(AW), .NREQ(N)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_addr(req_addr),
    .req_data(req_data), .req_ready(req_ready), .hold(hold), .write(write),
    .wa0(wa0), .wa1(wa1), .wd0(wd0), .wd1(wd1), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  int          m_p;
  logic [1:0]  m_write;
  logic [4:0]  m_wa0, m_wa1;
  logic [31:0] m_wd0, m_wd1;
  logic        m_busy;

  function automatic logic [4:0] addr_of(input int r);
    return req_addr[r*AW +: AW];
  endfunction

  function automatic logic [31:0] data_of(input int r);
    return req_data[r*32 +: 32];
  endfunction

  task automatic model_reset();
    m_p = 0; m_write = 2'b00; m_wa0 = '0; m_wa1 = '0; m_wd0 = '0; m_wd1 = '0; m_busy = 1'b0;
  endtask

  // Valid requesters listed in scan order from p; first wins port 0, the first
  // later one with a different address wins port 1.
  task automatic model_grant(output logic [2:0] rdy, output int g0, output int g1);
    int cand[$];
    rdy = '0; g0 = -1; g1 = -1;
    if (!hold) begin
      for (int k = 0; k < N; k++)
        if (req_valid[(m_p + k) % N]) cand.push_back((m_p + k) % N);
      if (cand.size() > 0) begin
        g0 = cand.pop_front();
        while (cand.size() > 0 && g1 < 0) begin
          int r;
          r = cand.pop_front();
          if (addr_of(r) != addr_of(g0)) g1 = r;
        end
      end
      if (g0 >= 0) rdy[g0] = 1'b1;
      if (g1 >= 0) rdy[g1] = 1'b1;
    end
  endtask

  task automatic model_commit(input int g0, input int g1, input logic [2:0] rdy);
    m_write = {g1 >= 0, g0 >= 0};
    if (g0 >= 0) begin m_wa0 = addr_of(g0); m_wd0 = data_of(g0); m_p = (g0 + 1) % N; end
    if (g1 >= 0) begin m_wa1 = addr_of(g1); m_wd1 = data_of(g1); m_p = (g1 + 1) % N; end
    m_busy = |(req_valid & ~rdy);
  endtask

  // one cycle: inputs already driven; check ready, clock, check registers
  task automatic step_chk(input string tag, output logic [2:0] rdy);
    int g0, g1;
    model_grant(rdy, g0, g1);
    #1;
    chk({tag, " ready"}, req_ready, rdy);
    @(posedge clk); #1;
    model_commit(g0, g1, rdy);
    chk({tag, " write"}, write, m_write);
    chk({tag, " wa0"}, wa0, m_wa0);
    chk({tag, " wd0"}, wd0, m_wd0);
    chk({tag, " wa1"}, wa1, m_wa1);
    chk({tag, " wd1"}, wd1, m_wd1);
    chk({tag, " busy"}, busy, m_busy);
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic [2:0]  valid;
    logic [14:0] addr;
    logic [95:0] data;
    logic        hold;
    logic [2:0]  ready;
    logic [1:0]  wr;
    logic [4:0]  wa0, wa1;
    logic [31:0] wd0, wd1;
    logic        busy;
  } vec_t;

  vec_t tbl[8];
  logic [2:0] last_rdy = '0;

  initial begin
    // p=0: two distinct requests both granted, p -> 2
    tbl[0] = '{3'b011, {5'd0, 5'd5, 5'd3}, {32'h0, 32'h22, 32'h11}, 1'b0,
               3'b011, 2'b11, 5'd3, 5'd5, 32'h11, 32'h22, 1'b0};
    // p=2: lone req2 at top address/data, p -> 0
    tbl[1] = '{3'b100, {5'd31, 5'd0, 5'd0}, {32'hFFFF_FFFF, 32'h0, 32'h0}, 1'b0,
               3'b100, 2'b01, 5'd31, 5'd5, 32'hFFFF_FFFF, 32'h22, 1'b0};
    // p=0: address conflict, only req0; busy; p -> 1
    tbl[2] = '{3'b011, {5'd0, 5'd7, 5'd7}, {32'h0, 32'hA1, 32'hA0}, 1'b0,
               3'b001, 2'b01, 5'd7, 5'd5, 32'hA0, 32'h22, 1'b1};
    // p=1: the blocked req1 now on port 0, p -> 2
    tbl[3] = '{3'b010, {5'd0, 5'd7, 5'd7}, {32'h0, 32'hA1, 32'hA0}, 1'b0,
               3'b010, 2'b01, 5'd7, 5'd5, 32'hA1, 32'h22, 1'b0};
    // hold: nothing granted, registers hold, p stays 2
    tbl[4] = '{3'b111, {5'd4, 5'd2, 5'd1}, {32'hB2, 32'hB1, 32'hB0}, 1'b1,
               3'b000, 2'b00, 5'd7, 5'd5, 32'hA1, 32'h22, 1'b1};
    // hold released: scan 2,0,1 -> ports 2 and 0, p -> 1
    tbl[5] = '{3'b111, {5'd4, 5'd2, 5'd1}, {32'hB2, 32'hB1, 32'hB0}, 1'b0,
               3'b101, 2'b11, 5'd4, 5'd1, 32'hB2, 32'hB0, 1'b1};
    // p=1: scan 1,2,0 -> ports 1 and 2, p -> 0
    tbl[6] = '{3'b111, {5'd4, 5'd2, 5'd1}, {32'hB2, 32'hB1, 32'hB0}, 1'b0,
               3'b110, 2'b11, 5'd2, 5'd4, 32'hB1, 32'hB2, 1'b1};
    // idle
    tbl[7] = '{3'b000, {5'd4, 5'd2, 5'd1}, {32'hB2, 32'hB1, 32'hB0}, 1'b0,
               3'b000, 2'b00, 5'd2, 5'd4, 32'hB1, 32'hB2, 1'b0};

    // reset held with requests pending: everything zero, nothing granted
    req_valid = 3'b111;
    req_addr  = {5'd4, 5'd2, 5'd1};
    req_data  = {32'hC2, 32'hC1, 32'hC0};
    @(posedge clk); @(posedge clk); #1;
    chk("rst ready", req_ready, 3'b000);
    chk("rst write", write, 2'b00);
    chk("rst wa0", wa0, 5'd0);
    chk("rst wa1", wa1, 5'd0);
    chk("rst wd0", wd0, 32'd0);
    chk("rst wd1", wd1, 32'd0);
    chk("rst busy", busy, 1'b0);
    rst = 1'b1;

    for (int i = 0; i < 8; i++) begin
      req_valid = tbl[i].valid;
      req_addr  = tbl[i].addr;
      req_data  = tbl[i].data;
      hold      = tbl[i].hold;
      #1;
      chk($sformatf("vec%0d ready", i), req_ready, tbl[i].ready);
      @(posedge clk); #1;
      chk($sformatf("vec%0d write", i), write, tbl[i].wr);
      chk($sformatf("vec%0d wa0", i), wa0, tbl[i].wa0);
      chk($sformatf("vec%0d wd0", i), wd0, tbl[i].wd0);
      chk($sformatf("vec%0d wa1", i), wa1, tbl[i].wa1);
      chk($sformatf("vec%0d wd1", i), wd1, tbl[i].wd1);
      chk($sformatf("vec%0d busy", i), busy, tbl[i].busy);
    end

    // mid-stream async reset while write=11
    rst = 1'b0; #1; rst = 1'b1;
    model_reset();
    req_valid = 3'b011;
    req_addr  = {5'd0, 5'd9, 5'd8};
    req_data  = {32'h0, 32'hD1, 32'hD0};
    hold      = 1'b0;
    step_chk("pre-rst", last_rdy);
    chk("pre-rst write11", write, 2'b11);
    #2; rst = 1'b0; #1;
    chk("async write", write, 2'b00);
    chk("async wa0", wa0, 5'd0);
    chk("async wd1", wd1, 32'd0);
    chk("async ready", req_ready, 3'b000);
    @(posedge clk); #1;
    chk("in-rst write", write, 2'b00);
    rst = 1'b1;
    model_reset();

    // all three valid, addresses 1/2/4, held two cycles from p=0
    req_valid = 3'b111;
    req_addr  = {5'd4, 5'd2, 5'd1};
    req_data  = {32'hE2, 32'hE1, 32'hE0};
    #1;
    chk("fair c1 ready", req_ready, 3'b011);
    step_chk("fair c1", last_rdy);
    chk("fair c1 busy", busy, 1'b1);
    #1;
    chk("fair c2 ready", req_ready, 3'b101);
    step_chk("fair c2", last_rdy);
    chk("fair c2 wa0", wa0, 5'd4);
    chk("fair c2 wa1", wa1, 5'd1);

    // randomized traffic; requests stay stable until granted
    for (int c = 0; c < 400; c++) begin
      for (int r = 0; r < N; r++) begin
        if (!req_valid[r] || last_rdy[r]) begin
          req_valid[r] = ($urandom_range(0, 9) < 6);
          req_addr[r*AW +: AW] = ($urandom_range(0, 7) == 0) ? AW'($urandom) : AW'($urandom_range(0, 3));
          req_data[r*32 +: 32] = $urandom;
        end
      end
      hold = ($urandom_range(0, 7) == 0);
      step_chk("rnd", last_rdy);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
